uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Serial transmit stage that sits directly downstream of the host-link data controller. It accepts bytes on a new_data/data/busy handshake and buffers them in a small FIFO. It shifts each byte out as an 8N1 UART frame on the tx pin. Block input gives host-side flow control, and busy tells the upstream controller when it must stop writing.

Parameters:
CLK_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range is 2 or more.
FIFO_DEPTH, 4, byte entries in the transmit FIFO; must be a power of 2 and at least 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
new_data  input  1  write strobe; each cycle it is high and busy is low writes one byte.
data  input  8  byte to transmit; sampled when new_data is high.
block  input  1  synchronous flow control; when high, no new frame may start.
busy  output  1  high when FIFO_DEPTH bytes are buffered OR block is high.
tx  output  1  serial line; idles high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx=1, FIFO empty, busy=block, state=IDLE, bit timer=0, bit index=0.
  - Reset mid-frame aborts the frame; tx returns high immediately.
- Write acceptance:
  - Rule: new_data=1 AND count<FIFO_DEPTH at the clock edge.
  - A pop in the same cycle does not free a slot for that write.
  - A write while full is silently dropped; FIFO contents and count are unchanged.
  - block does not inhibit writes; only full does.
- busy is combinational from the registered count and block. busy=(count==FIFO_DEPTH)|block.
- Frame format: start bit 0, then data[0]..data[7] (LSB first), then stop bit 1. Each bit lasts exactly CLK_PER_BIT cycles, so a frame is 10*CLK_PER_BIT cycles.
- tx is driven from a register (glitch-free).
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO not empty and block=0, pop the head into the shift register, set tx<=0, clear the timer, and go to START.
  - START: after CLK_PER_BIT cycles, drive tx<=shift[0] and go to DATA.
  - DATA: every CLK_PER_BIT cycles, shift right and increment the index. After the 8th bit completes, set tx<=1 and go to STOP.
  - STOP: on the last stop-bit cycle, if FIFO not empty and block=0, pop and go straight to START with tx<=0 (zero idle gap). Otherwise go to IDLE.
- Latency: byte sampled at edge k into an empty FIFO with block=0 → tx low from edge k+1.
- block is checked only at frame boundaries (IDLE or the end of STOP). A frame already started always completes.
- Timer width is clog2(CLK_PER_BIT); index is 3 bits. Both wrap or clear only under FSM control.
- FIFO pointers are clog2(FIFO_DEPTH) bits with natural wrap. count is clog2(FIFO_DEPTH)+1 bits.
- Simultaneous push and pop (FIFO not full): count is unchanged, and the head byte is popped before the new byte is visible. The new byte is never popped in its own write cycle.

Decomposition:
- Shared package uart_pkg holds:
  - the tx state enum (IDLE/START/DATA/STOP);
  - FRAME_BITS=10;
  - the default CLK_PER_BIT.
- Sub-module byte_fifo holds the synchronous FIFO: WIDTH=8, DEPTH=FIFO_DEPTH, push/pop/full/empty/count, async active-low reset.
- uart_tx_fifo contains byte_fifo plus the serializer FSM.

Test Plan:
(All tests use CLK_PER_BIT=4 and FIFO_DEPTH=4.)
- Reset idle: hold rst_n low 5 cycles, release, no stimulus for 100 cycles → tx=1 and busy=0 throughout.
- Single byte: write 0xA5 at edge k → tx low over cycles k+1..k+4. Then bits 1,0,1,0,0,1,0,1 for 4 cycles each, stop bit high for 4 cycles, tx=1 at k+41, busy=0 throughout.
- Fill/overflow: block=1, write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles → busy=1 throughout, count=4, 0x05 dropped. Drop block → four back-to-back frames (160 cycles, no gap) carrying 0x01..0x04 with block=0 → busy low after the first pop.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles → second start bit begins on the cycle after the first stop bit ends; total 80 cycles of frames.
- Block mid-frame: raise block at cycle 10 of a frame with a second byte queued → first frame completes intact. tx stays high while block=1; second frame starts 1 cycle after block drops.
- Reset mid-frame: assert rst_n low during data bit 3 with 2 bytes queued → tx=1 asynchronously and FIFO empty. After release, busy=0 and no further frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_e      : serializer FSM states (IDLE/START/DATA/STOP)
//   FRAME_BITS      : bits per 8N1 frame (start + 8 data + stop)
//   DEF_CLK_PER_BIT : default bit period in clocks (100 MHz / 115200)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int FRAME_BITS      = 10;
    localparam int DEF_CLK_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side byte handshake for the UART transmitter.
//   new_data : write strobe from the upstream controller
//   data     : byte to transmit, valid while new_data is high
//   busy     : transmitter cannot take more bytes (FIFO full or blocked)
// master = upstream controller, slave = uart_tx_fifo.
interface uart_tx_fifo_if;

    logic       new_data;
    logic [7:0] data;
    logic       busy;

    modport master (
        output new_data,
        output data,
        input  busy
    );

    modport slave (
        input  new_data,
        input  data,
        output busy
    );

endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Synchronous byte FIFO feeding the UART serializer.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wr_data : write request; ignored while full
//   pop/rd_data  : read request; rd_data always shows the head entry
//   full, empty, count : occupancy status, count is clog2(DEPTH)+1 bits
// A write in the same cycle as a pop is still refused when full, and a byte
// written this cycle can never be the one popped this cycle.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = push & ~full;
    assign rd_ok   = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any frame)
//   host       : new_data/data/busy byte handshake (slave side)
//   block      : flow control; while high no new frame is started
//   tx         : registered serial output, idles high
// busy = FIFO full OR block. block is only looked at on frame boundaries,
// so a frame that has started always finishes.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave host,
    input  logic          block,
    output logic          tx
);
    localparam int            TW       = $clog2(CLK_PER_BIT);
    localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] T_LAST   = TW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(FRAME_BITS - 3);

    tx_state_e     state;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [7:0]    shift;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          bit_end;
    logic          start_frame;
    logic          shift_en;

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (host.new_data & ~fifo_full),
        .wr_data (host.data),
        .pop     (start_frame),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign host.busy = (fifo_count == CW'(FIFO_DEPTH)) | block;

    assign bit_end = (timer == T_LAST);

    // A frame may start from IDLE, or on the last stop-bit cycle so that
    // queued bytes go out with no idle gap between frames.
    assign start_frame = ~fifo_empty & ~block &
                         ((state == IDLE) | ((state == STOP) & bit_end));

    // shift[0] always holds the next data bit to put on the line.
    assign shift_en = bit_end &
                      ((state == START) | ((state == DATA) & (idx != LAST_IDX)));

    always_ff @(posedge clk) begin
        if (start_frame)   shift <= fifo_head;
        else if (shift_en) shift <= shift >> 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tx    <= 1'b1;
            timer <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        tx    <= 1'b0;
                        timer <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shift[0];
                        timer <= '0;
                        idx   <= '0;
                        state <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        idx   <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx <= shift[0];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (start_frame) begin
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (CLK_PER_BIT=4, FIFO_DEPTH=4).
// A frame-level model (byte queue + elapsed-cycle counter of the current
// frame) predicts tx and busy every cycle; directed scenarios add literal
// expectations, followed by a randomized traffic phase.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic block = 1'b0;
    logic tx;

    uart_tx_fifo_if hif ();

    uart_tx_fifo #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (hif),
        .block (block),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    bit         m_active  = 1'b0;
    int         m_elapsed = 0;
    logic [7:0] m_byte    = 8'h00;
    int         m_pre;
    bit         m_done;

    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_elapsed / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_active  = 1'b0;
                m_elapsed = 0;
            end else begin
                m_pre  = mq.size();
                m_done = !m_active || (m_elapsed == FRAME_CYC - 1);
                if (m_active) begin
                    m_elapsed++;
                    if (m_elapsed == FRAME_CYC) m_active = 1'b0;
                end
                if (m_done && m_pre > 0 && !block) begin
                    m_byte    = mq.pop_front();
                    m_active  = 1'b1;
                    m_elapsed = 0;
                end
                if (hif.new_data && m_pre < DEPTH) mq.push_back(hif.data);
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("tx_model", {31'd0, tx}, {31'd0, exp_tx()});
            chk("busy_model", {31'd0, hif.busy},
                {31'd0, (mq.size() == DEPTH) | block});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic frame_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        hif.new_data = 1'b0;
        hif.data     = 8'h00;

        // Reset idle
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("idle_tx", {31'd0, tx}, 32'd1);
        chk("idle_busy", {31'd0, hif.busy}, 32'd0);

        // Single byte 0xA5
        hif.new_data = 1'b1;
        hif.data     = 8'hA5;
        tick();
        hif.new_data = 1'b0;
        for (int i = 1; i <= 44; i++) begin
            @(negedge clk);
            if (i <= 40) chk("a5_bit", {31'd0, tx}, {31'd0, frame_a5[(i-1)/CPB]});
            else         chk("a5_idle", {31'd0, tx}, 32'd1);
            chk("a5_busy", {31'd0, hif.busy}, 32'd0);
        end
        repeat (10) tick();

        // Fill / overflow under block
        block = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            hif.new_data = 1'b1;
            hif.data     = 8'(v);
            tick();
            chk("fill_busy", {31'd0, hif.busy}, 32'd1);
        end
        hif.new_data = 1'b0;
        tick();
        chk("fill_tx_hold", {31'd0, tx}, 32'd1);
        block = 1'b0;
        #1;
        chk("full_busy", {31'd0, hif.busy}, 32'd1);
        for (int j = 0; j <= 160; j++) begin
            @(negedge clk);
            if (j % FRAME_CYC == 0 && j < 160) chk("fill_start", {31'd0, tx}, 32'd0);
            if (j == 0) chk("fill_busy_pop", {31'd0, hif.busy}, 32'd0);
        end
        chk("fill_end_tx", {31'd0, tx}, 32'd1);
        repeat (10) tick();

        // Back-to-back 0x00, 0xFF
        hif.new_data = 1'b1;
        hif.data     = 8'h00;
        tick();
        hif.data     = 8'hFF;
        tick();
        hif.new_data = 1'b0;
        repeat (39) @(negedge clk);
        chk("b2b_stop1", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("b2b_start2", {31'd0, tx}, 32'd0);
        repeat (4) @(negedge clk);
        chk("b2b_ff_b0", {31'd0, tx}, 32'd1);
        repeat (50) tick();

        // Block mid-frame
        hif.new_data = 1'b1;
        hif.data     = 8'h3C;
        tick();
        hif.data     = 8'h5A;
        tick();
        hif.new_data = 1'b0;
        repeat (8) tick();
        block = 1'b1;
        repeat (55) tick();
        chk("blk_tx_hold", {31'd0, tx}, 32'd1);
        chk("blk_busy", {31'd0, hif.busy}, 32'd1);
        block = 1'b0;
        @(negedge clk);
        chk("blk_restart", {31'd0, tx}, 32'd0);
        repeat (45) tick();

        // Reset mid-frame during data bit 3
        for (int v = 0; v < 3; v++) begin
            hif.new_data = 1'b1;
            hif.data     = 8'h11 * 8'(v + 1);
            tick();
        end
        hif.new_data = 1'b0;
        repeat (16) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, hif.busy}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("rst_after_tx", {31'd0, tx}, 32'd1);
        chk("rst_after_busy", {31'd0, hif.busy}, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            hif.new_data = ($urandom_range(0, 3) == 0);
            hif.data     = 8'($urandom);
            if ($urandom_range(0, 59) == 0) block = ~block;
        end
        tick();
        hif.new_data = 1'b0;
        block        = 1'b0;
        repeat (250) tick();
        chk("final_tx", {31'd0, tx}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
